debounce_pulsadores: RTL and testbench

- Conditions the three raw board pushbuttons before they reach the 1 Hz divider / inactivity-reset stage.
- For each button it synchronises the raw input to clk_in and removes contact bounce with a per-button state machine and counter.
- Outputs are clean registered press levels P1..P3 for the downstream stage, plus one-cycle press pulses for edge-triggered logic.

---
 rtl/debounce_pulsadores.sv | 121 ++++++++++++
 tb/tb_debounce_pulsadores.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/debounce_pulsadores.sv
// debounce_pulsadores: synchronises and debounces three raw pushbuttons.
// Each button goes through a 2-flop synchroniser and an independent
// four-state FSM with a stability counter. Outputs are the registered
// debounced levels P1..P3, a one-cycle press pulse per button, and the
// OR of those pulses.
module debounce_pulsadores #(
  parameter int CONT_DEB   = 80000,
  parameter int ANCHO_CONT = 17
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [2:0] btn_raw,
  output logic       P1,
  output logic       P2,
  output logic       P3,
  output logic [2:0] pulso,
  output logic       alguna
);

  localparam logic [1:0] REPOSO        = 2'd0;
  localparam logic [1:0] ESPERA_PRES   = 2'd1;
  localparam logic [1:0] PRESIONADO    = 2'd2;
  localparam logic [1:0] ESPERA_SUELTA = 2'd3;

  localparam logic [ANCHO_CONT-1:0] CNT_FIN = ANCHO_CONT'(CONT_DEB - 1);
  localparam logic [ANCHO_CONT-1:0] CNT_UNO = ANCHO_CONT'(1);

  logic [2:0]                 sync1_q;
  logic [2:0]                 s_q;
  logic [2:0][1:0]            state_q, state_d;
  logic [2:0][ANCHO_CONT-1:0] cnt_q, cnt_d;
  logic [2:0]                 p_q, p_d;
  logic [2:0]                 pulso_q, pulso_d;

  // Two-flop synchroniser per button; only s_q feeds the FSMs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= btn_raw;
      s_q     <= sync1_q;
    end
  end

  // Next-state logic for the three independent debounce FSMs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    pulso_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      case (state_q[i])
        REPOSO: begin
          if (s_q[i]) begin
            state_d[i] = ESPERA_PRES;
            cnt_d[i]   = '0;
          end
        end
        ESPERA_PRES: begin
          if (!s_q[i]) begin
            state_d[i] = REPOSO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_FIN) begin
            state_d[i] = PRESIONADO;
            cnt_d[i]   = '0;
            p_d[i]     = 1'b1;
            pulso_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_UNO;
          end
        end
        PRESIONADO: begin
          if (!s_q[i]) begin
            state_d[i] = ESPERA_SUELTA;
            cnt_d[i]   = '0;
          end
        end
        ESPERA_SUELTA: begin
          if (s_q[i]) begin
            state_d[i] = PRESIONADO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_FIN) begin
            state_d[i] = REPOSO;
            cnt_d[i]   = '0;
            p_d[i]     = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_UNO;
          end
        end
        default: begin
          state_d[i] = REPOSO;
          cnt_d[i]   = '0;
          p_d[i]     = 1'b0;
        end
      endcase
    end
  end

  // FSM state, counters, debounced levels and press pulses.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= {3{REPOSO}};
      cnt_q   <= '0;
      p_q     <= '0;
      pulso_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      pulso_q <= pulso_d;
    end
  end

  assign P1     = p_q[0];
  assign P2     = p_q[1];
  assign P3     = p_q[2];
  assign pulso  = pulso_q;
  assign alguna = |pulso_q;

endmodule

// File: tb/tb_debounce_pulsadores.sv
// Testbench for debounce_pulsadores: directed and random button activity,
// a reference model pushing expected outputs per clock into a queue, and a
// monitor popping and comparing on the opposite clock edge.
module tb_debounce_pulsadores;

  localparam int CONT_DEB   = 4;
  localparam int ANCHO_CONT = 3;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic [2:0] btn_raw = '0;
  logic       P1, P2, P3;
  logic [2:0] pulso;
  logic       alguna;

  int checks = 0;
  int errors = 0;

  debounce_pulsadores #(
    .CONT_DEB   (CONT_DEB),
    .ANCHO_CONT (ANCHO_CONT)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .btn_raw (btn_raw),
    .P1      (P1),
    .P2      (P2),
    .P3      (P3),
    .pulso   (pulso),
    .alguna  (alguna)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [2:0] lvl;
    logic [2:0] pul;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the FSMs see the raw level sampled two edges earlier.
  // A button's accepted level flips once it has disagreed with the sampled
  // level on CONT_DEB+1 consecutive edges; a flip to 1 is a press pulse.
  logic [2:0] h1 = '0, h2 = '0;
  logic [2:0] lvl_m = '0;
  int         run_m [3];
  always @(posedge clk_in) begin
    exp_t e;
    logic [2:0] obs;
    e.pul = '0;
    if (reset) begin
      h1 = '0; h2 = '0; lvl_m = '0;
      for (int i = 0; i < 3; i++) run_m[i] = 0;
    end else begin
      obs = h2;
      h2  = h1;
      h1  = btn_raw;
      for (int i = 0; i < 3; i++) begin
        if (obs[i] != lvl_m[i]) run_m[i] = run_m[i] + 1;
        else                    run_m[i] = 0;
        if (run_m[i] == CONT_DEB + 1) begin
          lvl_m[i] = obs[i];
          run_m[i] = 0;
          e.pul[i] = obs[i];
        end
      end
    end
    e.lvl = lvl_m;
    exp_q.push_back(e);
  end

  // Monitor: outputs are compared mid-cycle; while reset is high every
  // output must already be cleared.
  always @(negedge clk_in) begin
    exp_t e;
    logic [2:0] lvl_a;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL queue_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (reset) e = '0;
      lvl_a = {P3, P2, P1};
      checks++;
      if (lvl_a !== e.lvl) begin
        errors++;
        $display("FAIL level t=%0t got P3P2P1=%b want %b", $time, lvl_a, e.lvl);
      end
      checks++;
      if (pulso !== e.pul) begin
        errors++;
        $display("FAIL pulso t=%0t got %b want %b", $time, pulso, e.pul);
      end
      checks++;
      if (alguna !== (|e.pul)) begin
        errors++;
        $display("FAIL alguna t=%0t got %b want %b", $time, alguna, |e.pul);
      end
    end
  end

  // Drive btn_raw = v for n cycles; changes land 3 time units after posedge.
  task automatic hold(input logic [2:0] v, input int n);
    btn_raw = v;
    repeat (n) begin
      @(posedge clk_in);
      #3;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk_in);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) run_m[i] = 0;
    repeat (2) @(posedge clk_in);
    #3;
    reset = 1'b0;

    // Idle
    hold(3'b000, 50);
    // Clean press on bit0, held
    hold(3'b001, 12);
    // Bounce on bit1 while bit0 held, then stable
    for (int k = 0; k < 2; k++) begin
      hold(3'b011, 2);
      hold(3'b001, 2);
    end
    hold(3'b011, 12);
    // Release bit0 with a 2-cycle glitch at release cycle 3
    hold(3'b010, 3);
    hold(3'b011, 2);
    hold(3'b010, 12);
    hold(3'b000, 12);
    // Bits 0 and 2 together
    hold(3'b101, 12);
    hold(3'b000, 12);
    // Reset while bit2 is mid-debounce, button kept held
    hold(3'b100, 4);
    pulse_reset();
    hold(3'b100, 12);
    hold(3'b000, 12);
    // Exact-threshold boundaries: excursions of CONT_DEB and CONT_DEB+1
    for (int k = CONT_DEB; k <= CONT_DEB + 1; k++) begin
      hold(3'b111, k);
      hold(3'b000, 10);
    end

    // Random activity: mixes short bounces and long stable stretches
    for (int seg = 0; seg < 150; seg++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) hold(v, $urandom_range(1, 3));
      else                           hold(v, $urandom_range(3, 12));
      if ($urandom_range(0, 29) == 0) pulse_reset();
    end
    hold(3'b000, 15);

    @(negedge clk_in);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
